// File: rtl/task_packet_master.sv
// Manager end of the byte-in / word-out task protocol: streams a loaded byte
// packet to a task, then collects and size-checks the answer word stream.
module task_packet_master #(
    parameter int IN_DEPTH       = 256,
    parameter int OUT_DEPTH      = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load_wr,
    input  logic [7:0]                   i_load_data,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [4:0]                   o_status,
    output logic [$clog2(OUT_DEPTH):0]   o_answer_words,
    output logic [11:0]                  o_answer_bytes,
    input  logic [$clog2(OUT_DEPTH)-1:0] i_rd_addr,
    output logic [31:0]                  o_rd_data,
    input  logic                         i_task_data_request,
    output logic                         o_task_data_valid,
    output logic [7:0]                   o_task_data,
    output logic                         o_task_data_last,
    input  logic                         i_task_answer_ready,
    input  logic [31:0]                  i_task_answer_data,
    input  logic                         i_task_answer_data_last,
    input  logic [11:0]                  i_task_answer_packet_size_in_bytes,
    output logic                         o_task_manager_ready
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IAW:0]   BONE = 1;
    localparam logic [OAW:0]   WONE = 1;
    localparam logic [IAW-1:0] IONE = 1;
    localparam logic [TW-1:0]  TONE = 1;

    typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;

    state_t         state;
    logic [7:0]     in_mem  [IN_DEPTH];
    logic [31:0]    out_mem [OUT_DEPTH];
    logic [IAW:0]   byte_cnt;
    logic [IAW-1:0] send_idx;
    logic [TW-1:0]  tmr;
    logic           load_ovf;

    logic           load_acc;
    logic           load_drop;
    logic [IAW:0]   byte_cnt_nxt;
    logic [IAW-1:0] fetch_idx;
    logic           word_xfer;
    logic           word_store;
    logic           timed_out;
    logic [OAW:0]   word_cnt_nxt;
    logic [11:0]    cap_bytes;
    logic           size_bad;

    // Buffers are full exactly when the count MSB is set (depths are 2^n).
    assign load_acc     = state == IDLE && i_load_wr && !byte_cnt[IAW];
    assign load_drop    = state == IDLE && i_load_wr && byte_cnt[IAW];
    assign byte_cnt_nxt = load_acc ? byte_cnt + BONE : byte_cnt;
    assign fetch_idx    = o_task_data_valid ? send_idx + IONE : '0;
    assign word_xfer    = o_task_manager_ready && i_task_answer_ready;
    assign word_store   = word_xfer && !o_answer_words[OAW];
    assign timed_out    = tmr == TW'(TIMEOUT_CYCLES - 1);
    assign word_cnt_nxt = o_answer_words + WONE;
    assign cap_bytes    = (o_answer_words == '0)
                        ? i_task_answer_packet_size_in_bytes
                        : o_answer_bytes;
    assign size_bad     = {20'd0, cap_bytes} != (32'(word_cnt_nxt) << 2);

    always_ff @(posedge i_clk) begin
        if (load_acc) in_mem[byte_cnt[IAW-1:0]] <= i_load_data;
    end

    always_ff @(posedge i_clk) begin
        if (word_store) out_mem[o_answer_words[OAW-1:0]] <= i_task_answer_data;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_rd_data <= '0;
        else        o_rd_data <= out_mem[i_rd_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state                <= IDLE;
            byte_cnt             <= '0;
            send_idx             <= '0;
            tmr                  <= '0;
            load_ovf             <= 1'b0;
            o_busy               <= 1'b0;
            o_done               <= 1'b0;
            o_status             <= '0;
            o_answer_words       <= '0;
            o_answer_bytes       <= '0;
            o_task_data_valid    <= 1'b0;
            o_task_data          <= '0;
            o_task_data_last     <= 1'b0;
            o_task_manager_ready <= 1'b0;
        end else begin
            o_done <= 1'b0;
            tmr    <= tmr + TONE;
            unique case (state)
                IDLE: begin
                    tmr      <= '0;
                    byte_cnt <= byte_cnt_nxt;
                    if (load_drop) begin
                        load_ovf    <= 1'b1;
                        o_status[1] <= 1'b1;
                    end
                    if (i_start) begin
                        o_status       <= {3'b000, load_ovf | load_drop,
                                           byte_cnt_nxt == '0};
                        o_answer_words <= '0;
                        o_answer_bytes <= '0;
                        send_idx       <= '0;
                        if (byte_cnt_nxt == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state  <= SEND;
                            o_busy <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // Next byte is fetched while the current one transfers.
                    if (!o_task_data_valid || i_task_data_request) begin
                        if (o_task_data_valid) tmr <= '0;
                        if (o_task_data_valid && o_task_data_last) begin
                            o_task_data_valid    <= 1'b0;
                            o_task_data_last     <= 1'b0;
                            o_task_data          <= '0;
                            o_task_manager_ready <= 1'b1;
                            state                <= COLLECT;
                        end else begin
                            o_task_data_valid <= 1'b1;
                            o_task_data       <= in_mem[fetch_idx];
                            o_task_data_last  <= {1'b0, fetch_idx} == byte_cnt - BONE;
                            send_idx          <= fetch_idx;
                        end
                    end else if (timed_out) begin
                        o_status[4]       <= 1'b1;
                        o_task_data_valid <= 1'b0;
                        o_task_data_last  <= 1'b0;
                        o_task_data       <= '0;
                        o_busy            <= 1'b0;
                        o_done            <= 1'b1;
                        state             <= DONE;
                    end
                end
                COLLECT: begin
                    if (word_xfer) begin
                        tmr            <= '0;
                        o_answer_words <= word_cnt_nxt;
                        if (o_answer_words == '0)
                            o_answer_bytes <= i_task_answer_packet_size_in_bytes;
                        if (o_answer_words[OAW]) o_status[2] <= 1'b1;
                        if (i_task_answer_data_last) begin
                            o_status[3]          <= size_bad;
                            o_task_manager_ready <= 1'b0;
                            o_busy               <= 1'b0;
                            o_done               <= 1'b1;
                            state                <= DONE;
                        end
                    end else if (timed_out) begin
                        o_status[4]          <= 1'b1;
                        o_task_manager_ready <= 1'b0;
                        o_busy               <= 1'b0;
                        o_done               <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE: begin
                    tmr      <= '0;
                    byte_cnt <= '0;
                    load_ovf <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
